// File: rtl/sccomp_sys.sv
// sccomp_sys : single-cycle MIPS-32 computer (CPU core, instruction ROM, data RAM).
// Every clock retires one instruction. The register write, the data RAM write and
// the PC update all happen on the rising edge of clk.
//
// Ports (top):
//   clk       in   system clock, rising edge active
//   rstn      in   asynchronous active-low reset
//   reg_sel   in   [4:0]  debug register index
//   reg_data  out  [31:0] contents of register reg_sel (combinational, 0 for r0)
//
// Build option: define SCCOMP_VSHIFT_EN to add sllv/srlv/srav (funct 04/06/07).
// Without it those funct codes execute as NOP.

module reg_file (
   input  logic        clk,
   input  logic        rstn,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  ra3,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] rd3
);
   logic [31:0] rf [0:31];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         rf[wa] <= wd;
      end
   end

   // Reads see the value held before the edge; a same-cycle write shows up next cycle.
   assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
   assign rd3 = (ra3 == 5'd0) ? '0 : rf[ra3];
endmodule

module instr_rom #(
   parameter int DEPTH = 128
) (
   input  logic [6:0]  word,
   output logic [31:0] instr
);
   // Contents are preloaded by the simulation environment; the core never writes here.
   logic [31:0] ROM [0:DEPTH-1];
   logic [6:0]  idx;

   assign idx   = 7'(32'(word) % DEPTH);
   assign instr = ROM[idx];
endmodule

module data_ram #(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   logic [31:0] ram [0:DEPTH-1];
   logic [6:0]  idx;
   wire         unused_addr = ^{addr[31:9], addr[1:0]};

   assign idx   = 7'(32'(addr[8:2]) % DEPTH);
   assign rdata = ram[idx];

   always_ff @(posedge clk) begin
      if (we) ram[idx] <= wdata;
   end
endmodule

module sccpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] instr,
   input  logic [31:0] dm_rdata,
   input  logic [4:0]  reg_sel,
   output logic [31:0] PC,
   output logic        mem_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [31:0] reg_data
);
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, wa;
   logic [15:0] imm;
   logic [31:0] a, b, sext, zext, pc_plus4, br_target, j_target, wd, pc_next;
   logic        rf_we;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];

   assign sext      = {{16{imm[15]}}, imm};
   assign zext      = {16'h0000, imm};
   assign pc_plus4  = PC + 32'd4;
   assign br_target = pc_plus4 + {sext[29:0], 2'b00};
   assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign dm_addr   = a + sext;
   assign dm_wdata  = b;

   reg_file U_RF (
      .clk(clk), .rstn(rstn), .we(rf_we),
      .ra1(rs), .ra2(rt), .ra3(reg_sel), .wa(wa), .wd(wd),
      .rd1(a), .rd2(b), .rd3(reg_data)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) PC <= RESET_PC;
      else       PC <= pc_next;
   end

   // Anything not decoded below falls through as a NOP: PC+4, no writes.
   always_comb begin
      rf_we   = 1'b0;
      mem_we  = 1'b0;
      wa      = rt;
      wd      = '0;
      pc_next = pc_plus4;
      case (op)
         6'h00: begin
            wa = rd;
            case (funct)
               6'h20, 6'h21: begin wd = a + b;                              rf_we = 1'b1; end
               6'h22, 6'h23: begin wd = a - b;                              rf_we = 1'b1; end
               6'h24:        begin wd = a & b;                              rf_we = 1'b1; end
               6'h25:        begin wd = a | b;                              rf_we = 1'b1; end
               6'h26:        begin wd = a ^ b;                              rf_we = 1'b1; end
               6'h27:        begin wd = ~(a | b);                           rf_we = 1'b1; end
               6'h2A:        begin wd = {31'd0, $signed(a) < $signed(b)};   rf_we = 1'b1; end
               6'h2B:        begin wd = {31'd0, a < b};                     rf_we = 1'b1; end
               6'h00:        begin wd = b << shamt;                         rf_we = 1'b1; end
               6'h02:        begin wd = b >> shamt;                         rf_we = 1'b1; end
               6'h03:        begin wd = $signed(b) >>> shamt;               rf_we = 1'b1; end
`ifdef SCCOMP_VSHIFT_EN
               6'h04:        begin wd = b << a[4:0];                        rf_we = 1'b1; end
               6'h06:        begin wd = b >> a[4:0];                        rf_we = 1'b1; end
               6'h07:        begin wd = $signed(b) >>> a[4:0];              rf_we = 1'b1; end
`endif
               6'h08:        pc_next = a;
               6'h09:        begin pc_next = a; wd = pc_plus4;              rf_we = 1'b1; end
               default:      ;
            endcase
         end
         6'h08, 6'h09: begin wd = a + sext;                       rf_we = 1'b1; end
         6'h0C:        begin wd = a & zext;                       rf_we = 1'b1; end
         6'h0D:        begin wd = a | zext;                       rf_we = 1'b1; end
         6'h0E:        begin wd = a ^ zext;                       rf_we = 1'b1; end
         6'h0F:        begin wd = {imm, 16'h0000};                rf_we = 1'b1; end
         6'h0A:        begin wd = {31'd0, $signed(a) < $signed(sext)}; rf_we = 1'b1; end
         6'h0B:        begin wd = {31'd0, a < sext};              rf_we = 1'b1; end
         6'h23:        begin wd = dm_rdata;                       rf_we = 1'b1; end
         6'h2B:        mem_we = 1'b1;
         6'h04:        if (a == b) pc_next = br_target;
         6'h05:        if (a != b) pc_next = br_target;
         6'h02:        pc_next = j_target;
         6'h03:        begin pc_next = j_target; wa = 5'd31; wd = pc_plus4; rf_we = 1'b1; end
         default:      ;
      endcase
   end
endmodule

module sccomp_sys #(
   parameter int          IM_DEPTH = 128,
   parameter int          DM_DEPTH = 128,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   wire [31:0] PC;
   wire [31:0] instr;
   wire        mem_we;
   wire [31:0] dm_addr, dm_wdata, dm_rdata;
   wire        unused_pc = ^{PC[31:9], PC[1:0]};

   sccpu #(.RESET_PC(RESET_PC)) U_SCPU (
      .clk(clk), .rstn(rstn), .instr(instr), .dm_rdata(dm_rdata), .reg_sel(reg_sel),
      .PC(PC), .mem_we(mem_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .reg_data(reg_data)
   );

   instr_rom #(.DEPTH(IM_DEPTH)) U_IM (
      .word(PC[8:2]), .instr(instr)
   );

   data_ram #(.DEPTH(DM_DEPTH)) U_DM (
      .clk(clk), .we(mem_we), .addr(dm_addr), .wdata(dm_wdata), .rdata(dm_rdata)
   );
endmodule

// File: tb/tb_sccomp_sys.sv
// Directed bench for sccomp_sys: programs are written into the ROM while reset is
// held, expected register values are queued when a program is loaded and popped
// against the debug read port once the program has run.

module tb_sccomp_sys;
   logic        clk;
   logic        rstn;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [4:0]  r;
      logic [31:0] v;
   } exp_t;
   exp_t sbq[$];

   sccomp_sys dut (.clk(clk), .rstn(rstn), .reg_sel(reg_sel), .reg_data(reg_data));

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] r_t(int rs, int rt, int rd, int sh, int fn);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   function automatic logic [31:0] i_t(int op, int rs, int rt, int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] j_t(int op, int tgt);
      return {op[5:0], tgt[25:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_reg(input string tag, input int r, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.r   = r[4:0];
      e.v   = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         reg_sel = e.r;
         #1;
         chk(e.tag, reg_data, e.v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [31:0] w);
      dut.U_IM.ROM[7'(i)] = w;
   endtask

   task automatic restart();
      rstn = 1'b0;
      #1;
      for (int i = 0; i < 128; i++) put(i, 32'h0);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rstn = 1'b1;
      #1;
   endtask

   task automatic check_rf_clear(input string tag);
      logic ok;
      ok = 1'b1;
      for (int i = 1; i < 32; i++)
         if (dut.U_SCPU.U_RF.rf[5'(i)] !== 32'h0) ok = 1'b0;
      chk(tag, {31'd0, ok}, 32'h1);
   endtask

   int sort_vals [8] = '{5, -3, 17, 0, 2, 9, -8, 4};
   logic [31:0] sorted [8] = '{32'hFFFFFFF8, 32'hFFFFFFFD, 32'h0, 32'h2,
                               32'h4, 32'h5, 32'h9, 32'h11};

   initial begin
      int n;
      rstn    = 1'b1;
      reg_sel = 5'd0;

      // ---------------- reset and ALU ----------------
      #5 rstn = 1'b0;
      #1;
      chk("reset_pc_async", dut.PC, 32'h0);
      check_rf_clear("reset_rf_clear");
      for (int i = 0; i < 128; i++) put(i, 32'h0);
      put(0, i_t(8'h08, 0, 7, 16'h1234));
      put(1, i_t(8'h0D, 7, 8, 16'h00FF));
      put(2, r_t(8, 7, 9, 0, 8'h22));
      put(3, i_t(8'h08, 0, 0, 1));
      expect_reg("alu_r7", 7, 32'h00001234);
      expect_reg("alu_r8", 8, 32'h000012FF);
      expect_reg("alu_r9", 9, 32'h000000CB);
      expect_reg("alu_r0", 0, 32'h0);
      release_rst();
      chk("pc_after_release", dut.PC, 32'h0);
      reg_sel = 5'd7;
      #1;
      chk("r7_before_write", reg_data, 32'h0);
      tick();
      chk("pc_edge1", dut.PC, 32'h4);
      chk("r7_after_write", reg_data, 32'h00001234);
      tick();
      chk("pc_edge2", dut.PC, 32'h8);
      repeat (6) tick();
      chk("r0_array_zero", dut.U_SCPU.U_RF.rf[0], 32'h0);
      drain();

      // ---------------- memory ----------------
      restart();
      put(0, i_t(8'h08, 0, 1, -5));
      put(1, i_t(8'h2B, 0, 1, 8));
      put(2, i_t(8'h23, 0, 2, 8));
      put(3, i_t(8'h08, 0, 0, 1));
      put(4, i_t(8'h08, 0, 3, 16'h0208));
      put(5, i_t(8'h23, 3, 4, 0));
      put(6, i_t(8'h23, 3, 14, -512));
      expect_reg("mem_r1", 1, 32'hFFFFFFFB);
      expect_reg("mem_lw_r2", 2, 32'hFFFFFFFB);
      expect_reg("mem_r0", 0, 32'h0);
      expect_reg("mem_wrap_r4", 4, 32'hFFFFFFFB);
      expect_reg("mem_negoff_r14", 14, 32'hFFFFFFFB);
      release_rst();
      repeat (9) tick();
      chk("mem_ram_word2", dut.U_DM.ram[2], 32'hFFFFFFFB);
      drain();

      // ---------------- control flow ----------------
      restart();
      put(0,  i_t(8'h08, 0, 1, 3));
      put(1,  i_t(8'h08, 0, 2, 3));
      put(2,  i_t(8'h04, 1, 2, 1));
      put(3,  i_t(8'h08, 0, 5, 16'h0055));
      put(4,  j_t(8'h03, 8));
      put(5,  i_t(8'h05, 1, 2, 1));
      put(6,  i_t(8'h08, 0, 6, 16'h0066));
      put(7,  j_t(8'h02, 16));
      put(8,  i_t(8'h0F, 0, 3, 16'h8000));
      put(9,  r_t(3, 0, 4, 0, 8'h2A));
      put(10, r_t(3, 0, 12, 0, 8'h2B));
      put(11, r_t(31, 0, 0, 0, 8'h08));
      put(16, i_t(8'h08, 0, 13, 16'h0077));
      put(17, j_t(8'h02, 17));
      expect_reg("beq_skip_r5", 5, 32'h0);
      expect_reg("bne_fall_r6", 6, 32'h66);
      expect_reg("jal_r31", 31, 32'h14);
      expect_reg("lui_r3", 3, 32'h80000000);
      expect_reg("slt_r4", 4, 32'h1);
      expect_reg("sltu_r12", 12, 32'h0);
      expect_reg("j_r13", 13, 32'h77);
      release_rst();
      repeat (3) tick();
      chk("beq_taken_pc", dut.PC, 32'h10);
      tick();
      chk("jal_pc", dut.PC, 32'h20);
      repeat (4) tick();
      chk("jr_return_pc", dut.PC, 32'h14);
      tick();
      chk("bne_fall_pc", dut.PC, 32'h18);
      repeat (10) tick();
      chk("j_loop_pc", dut.PC, 32'h44);
      drain();

      // ---------------- shifts, logic, unknowns, jalr, ROM wrap ----------------
      restart();
      put(0,  i_t(8'h0F, 0, 1, 16'h8000));
      put(1,  r_t(0, 1, 2, 4, 8'h03));
      put(2,  r_t(0, 1, 3, 4, 8'h02));
      put(3,  r_t(0, 1, 4, 1, 8'h00));
      put(4,  r_t(0, 0, 5, 0, 8'h27));
      put(5,  i_t(8'h0E, 5, 6, 16'hFFFF));
      put(6,  i_t(8'h0C, 5, 7, 16'h8000));
      put(7,  i_t(8'h0B, 0, 8, -1));
      put(8,  i_t(8'h0A, 0, 9, -1));
      put(9,  i_t(8'h3F, 0, 11, 16'h1234));
      put(10, r_t(5, 5, 11, 0, 8'h3F));
      put(11, r_t(5, 5, 10, 0, 8'h20));
      put(12, i_t(8'h08, 0, 20, 16'h0240));
      put(13, r_t(20, 0, 21, 0, 8'h09));
      put(14, i_t(8'h08, 0, 23, 1));
      put(16, i_t(8'h08, 0, 22, 16'h005A));
      put(17, j_t(8'h02, 16'h0091));
      expect_reg("sra_r2", 2, 32'hF8000000);
      expect_reg("srl_r3", 3, 32'h08000000);
      expect_reg("sll_r4", 4, 32'h0);
      expect_reg("nor_r5", 5, 32'hFFFFFFFF);
      expect_reg("xori_r6", 6, 32'hFFFF0000);
      expect_reg("andi_r7", 7, 32'h00008000);
      expect_reg("sltiu_r8", 8, 32'h1);
      expect_reg("slti_r9", 9, 32'h0);
      expect_reg("add_nowrap_r10", 10, 32'hFFFFFFFE);
      expect_reg("unknown_r11", 11, 32'h0);
      expect_reg("jalr_link_r21", 21, 32'h38);
      expect_reg("rom_wrap_r22", 22, 32'h5A);
      expect_reg("jalr_skip_r23", 23, 32'h0);
      release_rst();
      repeat (25) tick();
      chk("rom_wrap_pc", dut.PC, 32'h244);
      drain();

      // ---------------- optional variable shifts ----------------
      restart();
      put(0, i_t(8'h08, 0, 6, 1));
      put(1, i_t(8'h08, 0, 7, 35));
      put(2, i_t(8'h08, 0, 5, 16'h0099));
      put(3, r_t(7, 6, 5, 0, 8'h04));
      put(4, i_t(8'h0F, 0, 8, 16'h8000));
      put(5, r_t(7, 8, 9, 0, 8'h07));
      put(6, r_t(7, 8, 10, 0, 8'h06));
`ifdef SCCOMP_VSHIFT_EN
      expect_reg("sllv_r5", 5, 32'h8);
      expect_reg("srav_r9", 9, 32'hF0000000);
      expect_reg("srlv_r10", 10, 32'h10000000);
`else
      expect_reg("sllv_nop_r5", 5, 32'h99);
      expect_reg("srav_nop_r9", 9, 32'h0);
      expect_reg("srlv_nop_r10", 10, 32'h0);
`endif
      release_rst();
      repeat (9) tick();
      drain();

      // ---------------- bubble sort with mid-program reset ----------------
      restart();
      for (int k = 0; k < 8; k++) begin
         put(2 * k,     i_t(8'h08, 0, 1, sort_vals[k]));
         put(2 * k + 1, i_t(8'h2B, 0, 1, 4 * k));
      end
      put(16, i_t(8'h08, 0, 2, 7));
      put(17, r_t(0, 2, 5, 0, 8'h20));
      put(18, i_t(8'h08, 0, 3, 0));
      put(19, i_t(8'h23, 3, 6, 0));
      put(20, i_t(8'h23, 3, 7, 4));
      put(21, r_t(7, 6, 8, 0, 8'h2A));
      put(22, i_t(8'h04, 8, 0, 2));
      put(23, i_t(8'h2B, 3, 7, 0));
      put(24, i_t(8'h2B, 3, 6, 4));
      put(25, i_t(8'h08, 3, 3, 4));
      put(26, i_t(8'h08, 5, 5, -1));
      put(27, i_t(8'h05, 5, 0, -9));
      put(28, i_t(8'h08, 2, 2, -1));
      put(29, i_t(8'h05, 2, 0, -13));
      put(30, j_t(8'h02, 16'h0020));
      put(32, j_t(8'h02, 16'h0020));
      for (int r = 0; r < 32; r++) begin
         logic [31:0] g;
         case (r)
            1:       g = 32'h4;
            3:       g = 32'h4;
            6:       g = 32'hFFFFFFF8;
            7:       g = 32'hFFFFFFFD;
            default: g = 32'h0;
         endcase
         expect_reg($sformatf("sort_r%0d", r), r, g);
      end
      release_rst();
      repeat (40) tick();
      rstn = 1'b0;
      #1;
      chk("midrst_pc", dut.PC, 32'h0);
      check_rf_clear("midrst_rf_clear");
      release_rst();
      n = 0;
      while (dut.PC !== 32'h80 && n < 1000) begin
         tick();
         n++;
      end
      chk("sort_reach_0x80", dut.PC, 32'h80);
      for (int k = 0; k < 8; k++)
         chk($sformatf("sort_mem%0d", k), dut.U_DM.ram[k], sorted[k]);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sccomp_sys.md
Name: sccomp_sys

Overview:
- Single-cycle MIPS-32 computer: CPU core, instruction ROM and data RAM in one top.
- Each clock executes one instruction completely. Register write, data-memory write and PC update all happen on the rising edge.
- A debug port reads any general register combinationally.
- Top-level system block for simulation; test programs are preloaded into the ROM.

Parameters:
- IM_DEPTH, 128: instruction ROM depth in 32-bit words.
- DM_DEPTH, 128: data RAM depth in 32-bit words.
- RESET_PC, 32'h00000000: PC value while and after reset.

Ports:
- clk  in  1  system clock; rising-edge active.
- rstn  in  1  asynchronous, active-low reset.
- reg_sel  in  5  debug register index.
- reg_data  out  32  contents of register reg_sel; combinational; 0 when reg_sel=0.

Behaviour:
- Required hierarchy, used by the bench through hierarchical paths:
  - top-level wires PC[31:0] and instr[31:0];
  - CPU instance U_SCPU containing reg PC and register-file instance U_RF with array rf[0:31] of 32-bit values;
  - ROM instance U_IM with array ROM[0:IM_DEPTH-1] of 32-bit words, loadable by $readmemh.
- Reset (rstn=0):
  - PC = RESET_PC immediately (asynchronous);
  - rf[1..31] cleared to 0;
  - data RAM not cleared.
- Fetch: instr = ROM[PC[8:2]], combinational. PC[1:0] ignored. An address beyond depth wraps modulo IM_DEPTH.
- rf[0] always reads 0; writes to register 0 are discarded.
- Supported instructions:
  - R-type, op 0, by funct: add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03, jr 08, jalr 09.
  - I-type, by op: addi 08, addiu 09, andi 0C, ori 0D, xori 0E, lui 0F, slti 0A, sltiu 0B, lw 23, sw 2B, beq 04, bne 05.
  - J-type, by op: j 02, jal 03.
- Immediates: sign-extended for addi, addiu, slti, sltiu, lw, sw, beq, bne; zero-extended for andi, ori, xori; lui loads imm<<16.
- Arithmetic: no overflow traps; add and addu behave identically, as do sub and subu. slt is signed; sltu/sltiu are unsigned.
- Shifts use shamt. sra is arithmetic.
- Next PC:
  - default PC+4;
  - taken branch: PC+4+(sext(imm)<<2);
  - j/jal: {PC+4[31:28], target, 2'b00};
  - jr/jalr: rs.
- jal writes PC+4 to r31; jalr writes PC+4 to rd.
- No delay slots.
- lw/sw: effective address rs+sext(imm), word index addr[8:2] modulo DM_DEPTH. sw writes on the rising edge. lw data is read combinationally and written to rt on the same edge.
- Unknown opcodes or funct codes execute as NOP: PC+4, no writes.
- Read-during-write: a register read in the same cycle as its write returns the old value; the new value is visible next cycle.
- Reset asserted mid-program: execution restarts at RESET_PC on release, with the ROM retained.

Optional Feature:
- Macro SCCOMP_VSHIFT_EN.
- Defined: adds the variable shifts sllv (funct 04), srlv (06) and srav (07), with shift amount rs[4:0] and operand rt.
- Undefined: funct 04, 06 and 07 execute as NOP.

Test Plan:
- Reset: rstn low at 5 ns → PC=0 immediately and rf[1..31]=0. After release, PC reads 0,4,8 on successive edges.
- ALU/readback: program addi r7,r0,0x1234; ori r8,r7,0x00FF; sub r9,r8,r7 → reg_sel=7 gives 0x00001234; r8=0x000012FF; r9=0x000000CB. reg_sel=0 gives 0.
- Memory: addi r1,r0,-5; sw r1,8(r0); lw r2,8(r0) → r2=0xFFFFFFFB. Write r0 via addi r0,r0,1 → r0 stays 0.
- Control flow:
  - beq with equal operands skips one instruction;
  - bne not-taken falls through;
  - jal at 0x10 gives r31=0x14;
  - jr r31 returns to 0x14;
  - lui r3,0x8000 then slt r4,r3,r0 gives 1, while sltu gives 0.
- Sort program: load an 8-word array, run a bubble sort stored in ROM, then loop at 0x80 → at PC=0x80 the memory words are in ascending order, the registers match the golden dump, and this happens within 1000 cycles.
- Option: with SCCOMP_VSHIFT_EN, sllv r5,r6,r7 where r6=1 and r7=35 gives 8. Without the macro, r5 is unchanged.
